// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array sequencer: default sizes,
// feed-phase length helper and the controller state encoding.
package systolic_pkg;

   localparam int DATA_SIZE_DEF = 4;
   localparam int N_DEF         = 4;

   // Cycles needed to push the last skewed operand through an n x n array
   function automatic int feed_len(input int n);
      return 3 * n - 2;
   endfunction

   localparam int FEED_LEN = feed_len(N_DEF);
   localparam int IDX_W    = $clog2(N_DEF);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      FEED  = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/systolic_operand_buf.sv
// N x N signed operand register file. One write port; the read side
// presents one skewed edge lane per row (or per column when TRANSPOSE=1)
// for feed counter i_f, zero where the lane has no element in range.
module systolic_operand_buf
   import systolic_pkg::*;
#(
   parameter int  DATA_SIZE = DATA_SIZE_DEF,
   parameter int  N         = N_DEF,
   parameter bit  TRANSPOSE = 1'b0,
   localparam int IW        = $clog2(N),
   localparam int F_W       = $clog2(feed_len(N))
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        i_we,
   input  logic [IW-1:0]               i_row,
   input  logic [IW-1:0]               i_col,
   input  logic signed [DATA_SIZE-1:0] i_data,
   input  logic [F_W-1:0]              i_f,
   output logic [N*DATA_SIZE-1:0]      o_edge
);

   logic signed [DATA_SIZE-1:0] r_mem [N][N];

   // Element storage: cleared by reset, last write to an element wins
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
               r_mem[r][c] <= '0;
      end else if (i_we) begin
         r_mem[i_row][i_col] <= i_data;
      end
   end

   // Lane l carries element index k = f - l while 0 <= k < N
   for (genvar l = 0; l < N; l++) begin : g_lane
      logic [F_W-1:0]              w_k;
      logic                        w_hit;
      logic signed [DATA_SIZE-1:0] w_val;

      assign w_k   = i_f - F_W'(l);
      assign w_hit = (i_f >= F_W'(l)) && (w_k < F_W'(N));

      if (TRANSPOSE) begin : g_col
         assign w_val = r_mem[w_k[IW-1:0]][l];
      end else begin : g_row
         assign w_val = r_mem[l][w_k[IW-1:0]];
      end

      assign o_edge[l*DATA_SIZE +: DATA_SIZE] = w_hit ? w_val : '0;
   end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an N x N output-stationary systolic MAC array. Holds the
// A and B operands, clears the PE accumulators for one cycle, then streams
// skewed rows of A west and columns of B north, and flags completion.
// Every output is registered from the next-state values so edges and
// control change together on the clock.
module systolic_seq_ctrl
   import systolic_pkg::*;
#(
   parameter int DATA_SIZE = DATA_SIZE_DEF,
   parameter int N         = N_DEF
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        ld_we,
   input  logic                        ld_sel,
   input  logic [$clog2(N)-1:0]        ld_row,
   input  logic [$clog2(N)-1:0]        ld_col,
   input  logic signed [DATA_SIZE-1:0] ld_data,
   output logic                        ld_ready,
   input  logic                        start,
   output logic                        busy,
   output logic                        pe_clr,
   output logic [N*DATA_SIZE-1:0]      a_edge,
   output logic [N*DATA_SIZE-1:0]      b_edge,
   output logic                        done,
   output logic                        res_valid
);

   localparam int LEN = feed_len(N);
   localparam int F_W = $clog2(LEN);

   state_t                   r_state, w_state_nxt;
   logic [F_W-1:0]           r_f, w_f_nxt;
   logic                     r_busy, r_pe_clr, r_done, r_res_valid;
   logic [N*DATA_SIZE-1:0]   r_a_edge, r_b_edge;
   logic                     w_rv_nxt, w_feed_nxt;
   logic                     w_wr_a, w_wr_b;
   logic [N*DATA_SIZE-1:0]   w_a_rd, w_b_rd;

   // Host writes are only taken while idle; a write coinciding with start
   // still lands before the first edge read
   assign w_wr_a = ld_we & ~r_busy & ~ld_sel;
   assign w_wr_b = ld_we & ~r_busy &  ld_sel;

   systolic_operand_buf #(
      .DATA_SIZE (DATA_SIZE),
      .N         (N),
      .TRANSPOSE (1'b0)
   ) u_buf_a (
      .clk    (clk),
      .reset  (reset),
      .i_we   (w_wr_a),
      .i_row  (ld_row),
      .i_col  (ld_col),
      .i_data (ld_data),
      .i_f    (w_f_nxt),
      .o_edge (w_a_rd)
   );

   systolic_operand_buf #(
      .DATA_SIZE (DATA_SIZE),
      .N         (N),
      .TRANSPOSE (1'b1)
   ) u_buf_b (
      .clk    (clk),
      .reset  (reset),
      .i_we   (w_wr_b),
      .i_row  (ld_row),
      .i_col  (ld_col),
      .i_data (ld_data),
      .i_f    (w_f_nxt),
      .o_edge (w_b_rd)
   );

   // Next state, next feed index and next result-valid flag
   always_comb begin
      w_state_nxt = r_state;
      w_f_nxt     = r_f;
      w_rv_nxt    = r_res_valid;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = CLEAR;
               w_rv_nxt    = 1'b0;
            end
         end
         CLEAR: begin
            w_state_nxt = FEED;
            w_f_nxt     = '0;
         end
         FEED: begin
            if (r_f == F_W'(LEN - 1))
               w_state_nxt = DONE;
            else
               w_f_nxt = r_f + 1'b1;
         end
         DONE: begin
            w_state_nxt = IDLE;
            w_rv_nxt    = 1'b1;
         end
         default: w_state_nxt = IDLE;
      endcase
      w_feed_nxt = (w_state_nxt == FEED);
   end

   // State and feed counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_f     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_f     <= w_f_nxt;
      end
   end

   // Registered outputs, derived from where the FSM is heading
   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy      <= 1'b0;
         r_pe_clr    <= 1'b0;
         r_done      <= 1'b0;
         r_res_valid <= 1'b0;
         r_a_edge    <= '0;
         r_b_edge    <= '0;
      end else begin
         r_busy      <= (w_state_nxt != IDLE);
         r_pe_clr    <= (w_state_nxt == CLEAR);
         r_done      <= (w_state_nxt == DONE);
         r_res_valid <= w_rv_nxt;
         r_a_edge    <= w_feed_nxt ? w_a_rd : '0;
         r_b_edge    <= w_feed_nxt ? w_b_rd : '0;
      end
   end

   assign ld_ready  = ~r_busy;
   assign busy      = r_busy;
   assign pe_clr    = r_pe_clr;
   assign done      = r_done;
   assign res_valid = r_res_valid;
   assign a_edge    = r_a_edge;
   assign b_edge    = r_b_edge;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench: sequencer driving a behavioural 4x4 output-stationary PE array.
// Stimulus updates a matrix-level model and pushes expected results to a
// scoreboard; a negedge monitor checks control/edges every cycle and pops
// the scoreboard on each done pulse.
module tb_systolic_seq_ctrl;

   localparam int DS  = 4;
   localparam int N   = 4;
   localparam int IW  = $clog2(N);
   localparam int AW  = 2 * DS + 1;
   localparam int RUN = 3 * N;           // done appears RUN cycles after start

   logic                 clk = 1'b0;
   logic                 reset, ld_we, ld_sel, start;
   logic [IW-1:0]        ld_row, ld_col;
   logic signed [DS-1:0] ld_data;
   logic                 ld_ready, busy, pe_clr, done, res_valid;
   logic [N*DS-1:0]      a_edge, b_edge;

   always #5 clk = ~clk;

   systolic_seq_ctrl #(.DATA_SIZE(DS), .N(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .ld_we     (ld_we),
      .ld_sel    (ld_sel),
      .ld_row    (ld_row),
      .ld_col    (ld_col),
      .ld_data   (ld_data),
      .ld_ready  (ld_ready),
      .start     (start),
      .busy      (busy),
      .pe_clr    (pe_clr),
      .a_edge    (a_edge),
      .b_edge    (b_edge),
      .done      (done),
      .res_valid (res_valid)
   );

   // ---------------- PE array (system under test, not the model) -------
   logic signed [DS-1:0] pa [N][N];
   logic signed [DS-1:0] pb [N][N];
   logic signed [AW-1:0] pc [N][N];

   for (genvar i = 0; i < N; i++) begin : g_r
      for (genvar j = 0; j < N; j++) begin : g_c
         logic signed [DS-1:0] in_a, in_b, ra, rb;
         logic signed [AW-1:0] rc, prod;
         if (j == 0) begin : g_w
            assign in_a = a_edge[i*DS +: DS];
         end else begin : g_i
            assign in_a = pa[i][j-1];
         end
         if (i == 0) begin : g_n
            assign in_b = b_edge[j*DS +: DS];
         end else begin : g_j
            assign in_b = pb[i-1][j];
         end
         assign prod = {{(AW-DS){in_a[DS-1]}}, in_a} * {{(AW-DS){in_b[DS-1]}}, in_b};
         always @(posedge clk) begin
            if (reset || pe_clr) begin
               ra <= '0; rb <= '0; rc <= '0;
            end else begin
               ra <= in_a; rb <= in_b; rc <= rc + prod;
            end
         end
         assign pa[i][j] = ra;
         assign pb[i][j] = rb;
         assign pc[i][j] = rc;
      end
   end

   // ---------------- reference model and scoreboard --------------------
   logic signed [DS-1:0] mA [N][N], mB [N][N];   // operand buffers as the host sees them
   logic signed [DS-1:0] rA [N][N], rB [N][N];   // operands captured by the current run
   int  pat [N][N];
   bit  run_live = 1'b0;
   bit  prev_resv = 1'b0;
   int  last_c0 = -1000;
   int  q_done [$];
   int  q_c [$];
   int  cmp_cnt = 0, err_cnt = 0;
   int  cyc = 0;
   bit  mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic bit model_busy(input int t);
      return run_live && (t - last_c0) >= 1 && (t - last_c0) <= RUN;
   endfunction

   function automatic int wrap_acc(input int s);
      int w;
      w = s & ((1 << AW) - 1);
      if (w >= (1 << (AW - 1))) w = w - (1 << AW);
      return w;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, $signed(act), $signed(exp));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   // One cycle of host activity; the model applies whatever the spec says
   // the controller accepts in this cycle
   task automatic drive(input bit we, input bit sel, input int r, input int c,
                        input int v, input bit st);
      int s;
      ld_we   = we;
      ld_sel  = sel;
      ld_row  = r[IW-1:0];
      ld_col  = c[IW-1:0];
      ld_data = v[DS-1:0];
      start   = st;
      if (we && !model_busy(cyc)) begin
         if (sel) mB[r][c] = v[DS-1:0];
         else     mA[r][c] = v[DS-1:0];
      end
      if (st && !model_busy(cyc)) begin
         prev_resv = run_live;
         run_live  = 1'b1;
         last_c0   = cyc;
         rA = mA;
         rB = mB;
         q_done.push_back(cyc + RUN);
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               s = 0;
               for (int k = 0; k < N; k++) s += int'(mA[i][k]) * int'(mB[k][j]);
               q_c.push_back(wrap_acc(s));
            end
      end
      tick();
      ld_we = 1'b0;
      start = 1'b0;
   endtask

   task automatic load_pat(input bit sel, input bit st_last);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            drive(1'b1, sel, r, c, pat[r][c], st_last && r == N-1 && c == N-1);
   endtask

   task automatic rand_pat();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            pat[r][c] = int'($urandom_range(15)) - 8;
   endtask

   task automatic fill_pat(input int v);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            pat[r][c] = v;
   endtask

   task automatic run_and_wait();
      drive(1'b0, 1'b0, 0, 0, 0, 1'b1);
      idle(RUN + 1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset     = 1'b0;
      run_live  = 1'b0;
      prev_resv = 1'b0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            mA[r][c] = '0;
            mB[r][c] = '0;
         end
      q_done.delete();
      q_c.delete();
   endtask

   // ---------------- monitor ----------------
   logic            e_busy, e_clr, e_done, e_rv;
   logic [N*DS-1:0] e_a, e_b;
   int              m_rel, m_k, m_dc;

   always @(negedge clk) begin
      if (mon_en) begin
         m_rel  = cyc - last_c0;
         e_busy = model_busy(cyc);
         e_clr  = run_live && m_rel == 1;
         e_done = run_live && m_rel == RUN;
         e_rv   = (run_live && m_rel > 0) ? (m_rel > RUN) : prev_resv;
         e_a    = '0;
         e_b    = '0;
         if (run_live && m_rel >= 2 && m_rel <= RUN - 1) begin
            for (int i = 0; i < N; i++) begin
               m_k = (m_rel - 2) - i;
               if (m_k >= 0 && m_k < N) begin
                  e_a[i*DS +: DS] = rA[i][m_k];
                  e_b[i*DS +: DS] = rB[m_k][i];
               end
            end
         end
         chk("ctrl{busy,pe_clr,done,res_valid,ld_ready}",
             {59'd0, busy, pe_clr, done, res_valid, ld_ready},
             {59'd0, e_busy, e_clr, e_done, e_rv, ~e_busy});
         chk("a_edge", {48'd0, a_edge}, {48'd0, e_a});
         chk("b_edge", {48'd0, b_edge}, {48'd0, e_b});
         if (done === 1'b1) begin
            if (q_done.size() == 0) begin
               chk("done_unexpected", 64'd1, 64'd0);
            end else begin
               m_dc = q_done.pop_front();
               chk("done_cycle", 64'(cyc), 64'(m_dc));
               for (int i = 0; i < N; i++)
                  for (int j = 0; j < N; j++)
                     chk($sformatf("out_c[%0d][%0d]", i, j),
                         64'(pc[i][j]), 64'(q_c.pop_front()));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1; ld_we = 1'b0; ld_sel = 1'b0; start = 1'b0;
      ld_row = '0; ld_col = '0; ld_data = '0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            mA[r][c] = '0; mB[r][c] = '0; rA[r][c] = '0; rB[r][c] = '0;
         end
      repeat (3) tick();
      reset  = 1'b0;
      mon_en = 1'b1;
      idle(2);

      // identity x ramp: C must equal B exactly
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) pat[r][c] = (r == c) ? 1 : 0;
      load_pat(1'b0, 1'b0);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) pat[r][c] = r * 4 + c - 8;
      load_pat(1'b1, 1'b0);
      run_and_wait();

      // accumulator wrap: -8*-8*4 = 256 -> -256; 7*-8*4 = -224
      fill_pat(-8); load_pat(1'b0, 1'b0); load_pat(1'b1, 1'b0);
      run_and_wait();
      fill_pat(7);  load_pat(1'b0, 1'b0);
      run_and_wait();

      // back-to-back runs; a start during FEED must be ignored
      rand_pat(); load_pat(1'b1, 1'b0);
      drive(1'b0, 1'b0, 0, 0, 0, 1'b1);
      idle(4);
      drive(1'b0, 1'b0, 0, 0, 0, 1'b1);
      idle(RUN - 5);
      drive(1'b0, 1'b0, 0, 0, 0, 1'b1);   // immediately in the first idle cycle
      idle(RUN + 1);
      rand_pat(); load_pat(1'b1, 1'b0);
      run_and_wait();

      // write during FEED dropped, same write later applied
      drive(1'b0, 1'b0, 0, 0, 0, 1'b1);
      idle(3);
      drive(1'b1, 1'b0, 0, 0, 5, 1'b0);
      idle(RUN - 3);
      drive(1'b1, 1'b0, 0, 0, 5, 1'b0);
      run_and_wait();

      // write and start in the same cycle
      rand_pat(); load_pat(1'b0, 1'b1);
      idle(RUN + 1);

      // reset at FEED f=5, then a fresh load and run
      drive(1'b0, 1'b0, 0, 0, 0, 1'b1);
      idle(6);
      do_reset();
      idle(2);
      rand_pat(); load_pat(1'b0, 1'b0);
      rand_pat(); load_pat(1'b1, 1'b0);
      run_and_wait();

      // random runs with stray writes while busy and repeated writes
      for (int t = 0; t < 4; t++) begin
         rand_pat(); load_pat(1'b0, 1'b0);
         rand_pat(); load_pat(1'b1, 1'b0);
         drive(1'b1, 1'b1, int'($urandom_range(N-1)), int'($urandom_range(N-1)),
               int'($urandom_range(15)) - 8, 1'b0);
         drive(1'b0, 1'b0, 0, 0, 0, 1'b1);
         idle(int'($urandom_range(2, RUN - 1)));
         drive(1'b1, t[0], int'($urandom_range(N-1)), int'($urandom_range(N-1)),
               int'($urandom_range(15)) - 8, 1'b0);
         idle(RUN + 2);
      end

      idle(3);
      chk("scoreboard_drained", 64'(q_done.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
